// File: rtl/alu_operand_regfile.sv
// alu_operand_regfile
//    Register file and flag register that sit directly in front of the 64-bit
//    ALU. Two read ports deliver registered operands, one write-back port
//    updates the array, and a 4-bit status register captures ALU flags.
//    Register ZERO_REG always reads as zero and discards writes.
//    Same-edge write-to-read forwarding makes a write visible to a read of the
//    same register at the same edge, so reads never return stale data.
//
// Ports
//    clock       single clock, all state changes on the rising edge
//    reset       synchronous, active-high; clears array, operands and flags
//    sa, sb      read addresses for operand A / operand B
//    da          write-back destination address
//    w_en        write enable for d_in into register da
//    d_in        write-back data
//    status_in   ALU status bits (opaque)
//    status_ld   load status_in into status_out
//    a_out       registered operand A (1-cycle read latency)
//    b_out       registered operand B (1-cycle read latency)
//    status_out  latched flags

module alu_operand_regfile #(
   parameter int DATA_WIDTH = 64,
   parameter int ADDR_WIDTH = 5,
   parameter int ZERO_REG   = 31
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [ADDR_WIDTH-1:0] sa,
   input  logic [ADDR_WIDTH-1:0] sb,
   input  logic [ADDR_WIDTH-1:0] da,
   input  logic                  w_en,
   input  logic [DATA_WIDTH-1:0] d_in,
   input  logic [3:0]            status_in,
   input  logic                  status_ld,
   output logic [DATA_WIDTH-1:0] a_out,
   output logic [DATA_WIDTH-1:0] b_out,
   output logic [3:0]            status_out
);

   localparam int NUM_REGS = 2 ** ADDR_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = ADDR_WIDTH'(ZERO_REG);

   logic [DATA_WIDTH-1:0] regs [NUM_REGS];
   logic [DATA_WIDTH-1:0] rd_a;
   logic [DATA_WIDTH-1:0] rd_b;
   logic                  wr_ok;

   assign wr_ok = w_en && (da != ZERO_ADDR);

   // Read muxes: zero register first, then same-edge forwarding, then array.
   // Forwarding uses wr_ok, so a write to the zero register never leaks out.
   always_comb begin
      rd_a = regs[sa];
      if (sa == ZERO_ADDR)
         rd_a = '0;
      else if (wr_ok && (da == sa))
         rd_a = d_in;
   end

   always_comb begin
      rd_b = regs[sb];
      if (sb == ZERO_ADDR)
         rd_b = '0;
      else if (wr_ok && (da == sb))
         rd_b = d_in;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < NUM_REGS; i++)
            regs[i] <= '0;
         a_out      <= '0;
         b_out      <= '0;
         status_out <= '0;
      end else begin
         if (wr_ok)
            regs[da] <= d_in;
         a_out <= rd_a;
         b_out <= rd_b;
         if (status_ld)
            status_out <= status_in;
      end
   end

endmodule

// File: tb/tb_alu_operand_regfile.sv
// tb_alu_operand_regfile
//    Directed bench for alu_operand_regfile. Inputs change 1 ns after the
//    rising edge and outputs are sampled at the same point, i.e. after the
//    edge that consumed the previous input set.

module tb_alu_operand_regfile;

   localparam int DW = 64;
   localparam int AW = 5;

   logic          clock;
   logic          reset;
   logic [AW-1:0] sa;
   logic [AW-1:0] sb;
   logic [AW-1:0] da;
   logic          w_en;
   logic [DW-1:0] d_in;
   logic [3:0]    status_in;
   logic          status_ld;
   logic [DW-1:0] a_out;
   logic [DW-1:0] b_out;
   logic [3:0]    status_out;

   int n_checks = 0;
   int n_errors = 0;

   alu_operand_regfile #(
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW),
      .ZERO_REG   (31)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .sa         (sa),
      .sb         (sb),
      .da         (da),
      .w_en       (w_en),
      .d_in       (d_in),
      .status_in  (status_in),
      .status_ld  (status_ld),
      .a_out      (a_out),
      .b_out      (b_out),
      .status_out (status_out)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   initial begin
      // Reset with coincident write and status load: both must be discarded.
      reset     = 1'b1;
      w_en      = 1'b1;
      da        = 5'd3;
      d_in      = 64'hFF;
      status_ld = 1'b1;
      status_in = 4'hF;
      sa        = 5'd3;
      sb        = 5'd3;
      tick();
      check("rst_a", a_out, 64'h0);
      check("rst_b", b_out, 64'h0);
      check("rst_status", {60'h0, status_out}, 64'h0);

      reset     = 1'b0;
      w_en      = 1'b0;
      status_ld = 1'b0;
      tick();
      check("rst_reg3_a", a_out, 64'h0);
      check("rst_reg3_b", b_out, 64'h0);
      check("rst_status_hold", {60'h0, status_out}, 64'h0);

      // Basic write then read, operands 10101 / 01010.
      w_en = 1'b1; da = 5'd5; d_in = 64'h15; tick();
      w_en = 1'b1; da = 5'd6; d_in = 64'h0A; tick();
      w_en = 1'b0; sa = 5'd5; sb = 5'd6; tick();
      check("rd_a_r5", a_out, 64'h15);
      check("rd_b_r6", b_out, 64'h0A);

      // Forwarding: new value wins over the old held value at the same edge.
      w_en = 1'b1; da = 5'd7; d_in = 64'h1; sa = 5'd5; sb = 5'd6; tick();
      w_en = 1'b1; da = 5'd7; d_in = 64'hDEAD_BEEF; sa = 5'd7; sb = 5'd7; tick();
      check("fwd_a", a_out, 64'hDEAD_BEEF);
      check("fwd_b", b_out, 64'hDEAD_BEEF);
      w_en = 1'b0; tick();
      check("fwd_stored_a", a_out, 64'hDEAD_BEEF);

      // Zero register: write ignored, no forwarding, reads 0 afterwards.
      w_en = 1'b1; da = 5'd31; d_in = '1; sa = 5'd31; sb = 5'd31; tick();
      check("zr_same_a", a_out, 64'h0);
      check("zr_same_b", b_out, 64'h0);
      w_en = 1'b0; tick();
      check("zr_next_a", a_out, 64'h0);
      check("zr_next_b", b_out, 64'h0);

      // Status load then hold.
      status_ld = 1'b1; status_in = 4'b1001; tick();
      check("st_load", {60'h0, status_out}, 64'h9);
      status_ld = 1'b0; status_in = 4'b0110;
      for (int k = 0; k < 3; k++) begin
         tick();
         check("st_hold", {60'h0, status_out}, 64'h9);
      end

      // Sweep: fill every writable register, then read pairs (i, 30-i).
      for (int i = 0; i <= 30; i++) begin
         w_en = 1'b1;
         da   = AW'(i);
         d_in = 64'(i) * 64'h0101;
         tick();
      end
      w_en = 1'b0;
      for (int i = 0; i <= 30; i++) begin
         sa = AW'(i);
         sb = AW'(30 - i);
         tick();
         check($sformatf("sweep_a%0d", i), a_out, 64'(i) * 64'h0101);
         check($sformatf("sweep_b%0d", i), b_out, 64'(30 - i) * 64'h0101);
      end

      // Reset mid-stream: array and flags cleared, first edge after is normal.
      sa = 5'd9; sb = 5'd9; tick();
      check("pre_rst_r9", a_out, 64'h0909);
      reset = 1'b1; tick();
      check("mid_rst_a", a_out, 64'h0);
      check("mid_rst_status", {60'h0, status_out}, 64'h0);
      reset = 1'b0;
      w_en  = 1'b1; da = 5'd4; d_in = 64'h44;
      sa    = 5'd4; sb = 5'd9;
      tick();
      check("post_rst_fwd_a", a_out, 64'h44);
      check("post_rst_r9_b", b_out, 64'h0);
      w_en = 1'b0; sa = 5'd9; sb = 5'd4; tick();
      check("post_rst_r9_a", a_out, 64'h0);
      check("post_rst_r4_b", b_out, 64'h44);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
